armleocpu_load_sequencer: RTL and testbench

Multi-cycle controller that owns the load-data path of the memory stage. It accepts one load request at a time and checks type and alignment before any bus access. It then issues a word-aligned read, waits for data with a bounded timeout, and extracts, shifts and extends the addressed byte/half/word. It returns the result or an exception cause to writeback over a valid/ready handshake, and sits between the execute/memory pipeline stage and the data-cache read port.

---
 rtl/armleocpu_load_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_armleocpu_load_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_load_sequencer
// Description : Memory-stage load controller. Accepts one load at a time,
//               screens type/alignment, performs a word-aligned bus read with
//               a bounded wait, extracts and extends the addressed
//               byte/half/word, and returns data or a cause to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module armleocpu_load_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // request from execute/memory stage
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    // data-cache read port
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rerr,
    // response to writeback
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic [2:0]  resp_cause
);

    // RISC-V funct3 load encodings
    localparam logic [2:0] c_LOAD_BYTE   = 3'b000;
    localparam logic [2:0] c_LOAD_HALF   = 3'b001;
    localparam logic [2:0] c_LOAD_WORD   = 3'b010;
    localparam logic [2:0] c_LOAD_BYTE_U = 3'b100;
    localparam logic [2:0] c_LOAD_HALF_U = 3'b101;

    // response causes
    localparam logic [2:0] c_CAUSE_OK       = 3'd0;
    localparam logic [2:0] c_CAUSE_MISALIGN = 3'd1;
    localparam logic [2:0] c_CAUSE_BADTYPE  = 3'd2;
    localparam logic [2:0] c_CAUSE_BUSERR   = 3'd3;
    localparam logic [2:0] c_CAUSE_TIMEOUT  = 3'd4;

    // timeout counter sized to hold TIMEOUT_CYCLES; a zero value disables it
    localparam int               c_CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT  = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic             c_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_req_ready;
    logic               r_mem_valid;
    logic [31:0]        r_mem_addr;
    logic               r_resp_valid;
    logic [31:0]        r_resp_data;
    logic [4:0]         r_resp_rd;
    logic [2:0]         r_resp_cause;
    logic [2:0]         r_type;
    logic [1:0]         r_off;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_flush_pend;   // flush seen in ADDR before the handshake
    logic               r_timed_out;    // current response is a timeout
    logic               r_late_beat;    // timed-out read's beat already arrived

    logic               w_type_legal;
    logic               w_misaligned;
    logic [31:0]        w_shifted;
    logic [31:0]        w_load_data;
    logic [c_CNT_W-1:0] w_cnt_next;

    assign req_ready  = r_req_ready;
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_rd    = r_resp_rd;
    assign resp_cause = r_resp_cause;

    assign w_cnt_next = r_cnt + c_CNT_W'(1);

    // Screen the incoming request: legal type and natural alignment
    always_comb begin
        w_type_legal = 1'b0;
        w_misaligned = 1'b0;
        case (req_type)
            c_LOAD_BYTE, c_LOAD_BYTE_U: w_type_legal = 1'b1;
            c_LOAD_HALF, c_LOAD_HALF_U: begin
                w_type_legal = 1'b1;
                w_misaligned = req_addr[0];
            end
            c_LOAD_WORD: begin
                w_type_legal = 1'b1;
                w_misaligned = (req_addr[1:0] != 2'b00);
            end
            default: w_type_legal = 1'b0;
        endcase
    end

    // Align the addressed lane to bit 0 and extend according to the load type
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        case (r_type)
            c_LOAD_BYTE:   w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_LOAD_BYTE_U: w_load_data = {24'h000000, w_shifted[7:0]};
            c_LOAD_HALF:   w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_LOAD_HALF_U: w_load_data = {16'h0000, w_shifted[15:0]};
            default:       w_load_data = w_shifted;
        endcase
    end

    // Sequencer: state and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_rd    <= 5'h0;
            r_resp_cause <= c_CAUSE_OK;
            r_type       <= 3'h0;
            r_off        <= 2'h0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_timed_out  <= 1'b0;
            r_late_beat  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready  <= 1'b0;
                        r_type       <= req_type;
                        r_off        <= req_addr[1:0];
                        r_resp_rd    <= req_rd;
                        r_flush_pend <= 1'b0;
                        r_timed_out  <= 1'b0;
                        r_late_beat  <= 1'b0;
                        // unknown type outranks misalignment; neither touches the bus
                        if (!w_type_legal) begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= 32'h0;
                            r_resp_cause <= c_CAUSE_BADTYPE;
                            r_state      <= S_RESP;
                        end else if (w_misaligned) begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= 32'h0;
                            r_resp_cause <= c_CAUSE_MISALIGN;
                            r_state      <= S_RESP;
                        end else begin
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_state     <= S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    // the address phase is never abandoned; a flush only redirects
                    if (mem_ready) begin
                        r_mem_valid  <= 1'b0;
                        r_cnt        <= '0;
                        r_flush_pend <= 1'b0;
                        r_state      <= (flush || r_flush_pend) ? S_DRAIN : S_DATA;
                    end else if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (flush) begin
                        if (mem_rvalid) begin
                            r_req_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (mem_rvalid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= mem_rerr ? 32'h0 : w_load_data;
                        r_resp_cause <= mem_rerr ? c_CAUSE_BUSERR : c_CAUSE_OK;
                        r_state      <= S_RESP;
                    end else if (c_TIMEOUT_EN) begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == c_TIMEOUT) begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= 32'h0;
                            r_resp_cause <= c_CAUSE_TIMEOUT;
                            r_timed_out  <= 1'b1;
                            r_late_beat  <= 1'b0;
                            r_state      <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    // a late beat arriving while the timeout response waits is consumed here
                    if (r_timed_out && mem_rvalid) begin
                        r_late_beat <= 1'b1;
                    end
                    if (flush || resp_ready) begin
                        r_resp_valid <= 1'b0;
                        // an outstanding timed-out beat must still be swallowed
                        if (r_timed_out && !r_late_beat && !mem_rvalid) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_req_ready <= 1'b1;
                            r_timed_out <= 1'b0;
                            r_late_beat <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end

                S_DRAIN: begin
                    if (mem_rvalid) begin
                        r_req_ready <= 1'b1;
                        r_timed_out <= 1'b0;
                        r_late_beat <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_mem_valid  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_armleocpu_load_sequencer
// Description : Self-checking bench for armleocpu_load_sequencer. A vector
//               table drives ordinary loads; responses are matched against a
//               queue of expected results. Hand sequences cover timeout,
//               flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_armleocpu_load_sequencer;

    localparam int c_TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_type = 3'h0;
    logic [4:0]  req_rd = 5'h0;
    logic        flush = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rerr = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [2:0]  resp_cause;

    always #5 clk = ~clk;

    armleocpu_load_sequencer #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .req_rd     (req_rd),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rerr   (mem_rerr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_cause (resp_cause)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        rerr;
        int          rdy_dly;
        int          rv_dly;
        int          resp_dly;
        logic [31:0] exp_data;
        logic [2:0]  exp_cause;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  cause;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[17];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response handshake must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            chk("resp_expected", {31'b0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("resp_data", resp_data, mon_e.data);
                chk("resp_cause", {29'b0, resp_cause}, {29'b0, mon_e.cause});
                chk("resp_rd", {27'b0, resp_rd}, {27'b0, mon_e.rd});
            end
        end
    end

    // Present a request and wait (bounded) until it is accepted; returns in cycle N+1
    task automatic accept(input logic [2:0] typ, input logic [31:0] addr, input logic [4:0] rd);
        int n;
        req_valid = 1'b1;
        req_addr  = addr;
        req_type  = typ;
        req_rd    = rd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            step();
            n++;
            @(negedge clk);
        end
        chk("req_ready", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic [31:0] a;
        accept(v.typ, v.addr, v.rd);
        e.data  = v.exp_data;
        e.cause = v.exp_cause;
        e.rd    = v.rd;
        sb.push_back(e);
        if (v.exp_cause == 3'd1 || v.exp_cause == 3'd2) begin
            resp_ready = (v.resp_dly == 0);
            @(negedge clk);
            chk("err_resp_latency", {31'b0, resp_valid}, 32'd1);
            chk("err_no_mem_valid", {31'b0, mem_valid}, 32'd0);
        end else begin
            a = {v.addr[31:2], 2'b00};
            for (int d = 0; d <= v.rdy_dly; d++) begin
                mem_ready = (d == v.rdy_dly);
                @(negedge clk);
                chk("mem_valid_hold", {31'b0, mem_valid}, 32'd1);
                chk("mem_addr", mem_addr, a);
                step();
            end
            mem_ready = 1'b0;
            for (int k = 0; k < v.rv_dly; k++) begin
                @(negedge clk);
                chk("wait_no_resp", {31'b0, resp_valid}, 32'd0);
                step();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            mem_rerr   = v.rerr;
            step();
            mem_rvalid = 1'b0;
            mem_rerr   = 1'b0;
            resp_ready = (v.resp_dly == 0);
            @(negedge clk);
            chk("resp_latency", {31'b0, resp_valid}, 32'd1);
        end
        for (int r = 1; r <= v.resp_dly; r++) begin
            step();
            resp_ready = (r == v.resp_dly);
            @(negedge clk);
            chk("resp_hold", {31'b0, resp_valid}, 32'd1);
        end
        step();
        resp_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", {31'b0, req_ready}, 32'd1);
        chk("resp_dropped", {31'b0, resp_valid}, 32'd0);
        step();
    endtask

    // Hard bound on the whole run
    initial begin
        #100000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "bench did not complete");
    end

    initial begin
        //            typ     addr          rd     rdata         rerr rdy rv resp exp_data      cause
        vt[0]  = '{3'b000, 32'h0000_1003, 5'd1,  32'h80AA_BBCC, 1'b0, 0, 0, 0, 32'hFFFF_FF80, 3'd0};
        vt[1]  = '{3'b101, 32'h0000_2002, 5'd2,  32'h9234_5678, 1'b0, 0, 0, 2, 32'h0000_9234, 3'd0};
        vt[2]  = '{3'b001, 32'h0000_2002, 5'd3,  32'h9234_5678, 1'b0, 0, 0, 0, 32'hFFFF_9234, 3'd0};
        vt[3]  = '{3'b010, 32'h0000_2001, 5'd4,  32'h0,         1'b0, 0, 0, 1, 32'h0,         3'd1};
        vt[4]  = '{3'b011, 32'h0000_2001, 5'd5,  32'h0,         1'b0, 0, 0, 0, 32'h0,         3'd2};
        vt[5]  = '{3'b010, 32'h0000_3000, 5'd6,  32'hDEAD_BEEF, 1'b0, 5, 0, 0, 32'hDEAD_BEEF, 3'd0};
        vt[6]  = '{3'b100, 32'h0000_1001, 5'd7,  32'h80AA_BBCC, 1'b0, 0, 2, 0, 32'h0000_00BB, 3'd0};
        vt[7]  = '{3'b000, 32'h0000_1002, 5'd8,  32'h80AA_BBCC, 1'b0, 0, 0, 0, 32'hFFFF_FFAA, 3'd0};
        vt[8]  = '{3'b001, 32'h0000_4000, 5'd9,  32'h1234_8001, 1'b0, 0, 0, 0, 32'hFFFF_8001, 3'd0};
        vt[9]  = '{3'b101, 32'h0000_4001, 5'd10, 32'h0,         1'b0, 0, 0, 0, 32'h0,         3'd1};
        vt[10] = '{3'b010, 32'h0000_5004, 5'd11, 32'h1234_5678, 1'b1, 0, 1, 0, 32'h0,         3'd3};
        vt[11] = '{3'b111, 32'h0000_6000, 5'd12, 32'h0,         1'b0, 0, 0, 0, 32'h0,         3'd2};
        vt[12] = '{3'b000, 32'h0000_7000, 5'd13, 32'h0000_007F, 1'b0, 0, 3, 0, 32'h0000_007F, 3'd0};
        vt[13] = '{3'b101, 32'h0000_7002, 5'd14, 32'h7FFF_0000, 1'b0, 0, 0, 0, 32'h0000_7FFF, 3'd0};
        vt[14] = '{3'b100, 32'h0000_7003, 5'd15, 32'hFF00_0000, 1'b0, 1, 1, 0, 32'h0000_00FF, 3'd0};
        vt[15] = '{3'b001, 32'h0000_7003, 5'd16, 32'h0,         1'b0, 0, 0, 0, 32'h0,         3'd1};
        vt[16] = '{3'b110, 32'h0000_7000, 5'd17, 32'h0,         1'b0, 0, 0, 0, 32'h0,         3'd2};

        // reset values while rst_n is held low
        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 17; i++) begin
            run_vec(vt[i]);
        end

        // timeout: handshake at M, cause 4 at M+1+TIMEOUT, late beat drained
        accept(3'b010, 32'h0000_8000, 5'd20);
        sb.push_back('{32'h0, 3'd4, 5'd20});
        mem_ready = 1'b1;
        @(negedge clk);
        chk("tmo_mem_valid", {31'b0, mem_valid}, 32'd1);
        step();
        mem_ready = 1'b0;
        for (int k = 0; k < c_TO; k++) begin
            @(negedge clk);
            chk("tmo_wait", {31'b0, resp_valid}, 32'd0);
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("tmo_resp_valid", {31'b0, resp_valid}, 32'd1);
        step();
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_busy", {31'b0, req_ready}, 32'd0);
            chk("drain_no_resp", {31'b0, resp_valid}, 32'd0);
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("drain_done", {31'b0, req_ready}, 32'd1);
        step();
        run_vec('{3'b010, 32'h0000_8004, 5'd21, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 32'hCAFE_F00D, 3'd0});

        // flush in DATA, beat three cycles later is drained silently
        accept(3'b000, 32'h0000_9000, 5'd22);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("fdata_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("fdata_busy", {31'b0, req_ready}, 32'd0);
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0011;
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("fdata_ready", {31'b0, req_ready}, 32'd1);
        chk("fdata_no_resp2", {31'b0, resp_valid}, 32'd0);
        step();

        // flush in ADDR: address stays up until accepted, then drain
        accept(3'b010, 32'h0000_C000, 5'd23);
        flush = 1'b1;
        @(negedge clk);
        step();
        flush = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("faddr_hold", {31'b0, mem_valid}, 32'd1);
        chk("faddr_addr", mem_addr, 32'h0000_C000);
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("faddr_drain", {31'b0, req_ready}, 32'd0);
        chk("faddr_mv_low", {31'b0, mem_valid}, 32'd0);
        step();
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("faddr_ready", {31'b0, req_ready}, 32'd1);
        step();

        // flush in RESP with resp_ready low
        accept(3'b001, 32'h0000_A002, 5'd24);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_1234;
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("fresp_valid", {31'b0, resp_valid}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fresp_dropped", {31'b0, resp_valid}, 32'd0);
        chk("fresp_ready", {31'b0, req_ready}, 32'd1);
        step();

        // asynchronous reset while waiting in DATA
        accept(3'b010, 32'h0000_B000, 5'd25);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("arst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("arst_resp_data", resp_data, 32'd0);
        chk("arst_resp_rd", {27'b0, resp_rd}, 32'd0);
        chk("arst_resp_cause", {29'b0, resp_cause}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        step();
        run_vec('{3'b000, 32'h0000_1003, 5'd26, 32'h80AA_BBCC, 1'b0, 0, 0, 0, 32'hFFFF_FF80, 3'd0});

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
